wb_ram_responder: RTL

Wishbone classic, single-transfer slave front-end for a synchronous block RAM, sitting on the data bus opposite the bexkat1p CPU master. It accepts cyc/stb requests, drives the RAM port, and returns exactly one ack_o or err_o pulse per transfer. It replaces free-running ack delay lines with a request-tracked, latency-parameterised responder. Read latency is configurable; out-of-range addresses are reported with err_o.

---
 rtl/wb_ram_responder_if.sv | 29 ++
 rtl/wb_ram_responder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/wb_ram_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_ram_responder_if
//  Description : Wishbone classic single-transfer bus bundle between the CPU
//                data master and the block-RAM responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_ram_responder_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [31:0] adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        output dat_o, ack_o, err_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        input  dat_o, ack_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : wb_ram_responder
//  Description : Wishbone classic slave front-end for a synchronous block RAM.
//                Tracks each request and returns exactly one ack or err pulse
//                per transfer; read latency is parameterised.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_ram_responder #(
    parameter int ADDR_WIDTH = 15,
    parameter int READ_LAT   = 1
) (
    input  wire logic                  clk_i,
    input  wire logic                  rst_i,
    wb_ram_responder_if.slave          bus,
    output logic [ADDR_WIDTH-1:0]      ram_addr,
    output logic [31:0]                ram_wdata,
    output logic                       ram_we,
    output logic [3:0]                 ram_be,
    input  wire logic [31:0]           ram_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    // Counter load value: RD_WAIT is left at the edge where the counter is 0.
    localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              lat_cnt;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [31:0]             rd_data;
    logic                    resp_err;
    logic                    resp_err_nxt;
    logic                    load_cnt;
    logic                    capture;
    logic                    req;
    logic                    in_range;
    logic                    ram_we_raw;
    logic                    unused_bits;

    assign req         = bus.cyc_i & bus.stb_i;
    // Byte offset within the word carries no meaning for a 32-bit RAM.
    assign unused_bits = ^bus.adr_i[1:0];

    // Out-of-range detection only exists when the RAM does not span the whole bus.
    generate
        if (ADDR_WIDTH >= 30) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_range_check
            assign in_range = (bus.adr_i[31:ADDR_WIDTH+2] == '0);
        end
    endgenerate

    assign ram_wdata = bus.dat_i;
    assign ram_be    = bus.sel_i;
    // Writes are never issued while reset is held.
    assign ram_we    = ram_we_raw & ~rst_i;

    assign bus.dat_o = rd_data;
    assign bus.ack_o = (state == RESP) & ~resp_err;
    assign bus.err_o = (state == RESP) &  resp_err;

    // Next-state, RAM strobe and address selection.
    always_comb begin
        state_nxt    = state;
        resp_err_nxt = resp_err;
        load_cnt     = 1'b0;
        capture      = 1'b0;
        ram_we_raw   = 1'b0;
        ram_addr     = (state == RD_WAIT) ? rd_addr : bus.adr_i[ADDR_WIDTH+1:2];
        case (state)
            IDLE: begin
                if (req) begin
                    if (!in_range) begin
                        state_nxt    = RESP;
                        resp_err_nxt = 1'b1;
                    end else if (bus.we_i) begin
                        ram_we_raw   = 1'b1;
                        state_nxt    = RESP;
                        resp_err_nxt = 1'b0;
                    end else begin
                        load_cnt     = 1'b1;
                        state_nxt    = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // Master abandoning the cycle takes priority over completion.
                if (!bus.cyc_i) begin
                    state_nxt = IDLE;
                end else if (lat_cnt == 2'd0) begin
                    capture      = 1'b1;
                    state_nxt    = RESP;
                    resp_err_nxt = 1'b0;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, latency counter, latched read address and read-data register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            lat_cnt  <= 2'd0;
            rd_addr  <= '0;
            rd_data  <= 32'd0;
            resp_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            resp_err <= resp_err_nxt;
            if (load_cnt) begin
                lat_cnt <= LAT_LOAD;
                rd_addr <= bus.adr_i[ADDR_WIDTH+1:2];
            end else if (state == RD_WAIT && lat_cnt != 2'd0) begin
                lat_cnt <= lat_cnt - 2'd1;
            end
            if (capture) begin
                rd_data <= ram_rdata;
            end
        end
    end

endmodule
`default_nettype wire
